// File: rtl/sys_bus_mem.sv
// sys_bus_mem: byte-wide memory and I/O responder on the CPU bus.
//
// The CPU bus has a 16-bit address and 8-bit data. This block holds the
// program/data RAM and keeps the CPU in reset while a program image is
// streamed in over a valid/ready loader port. The optional I/O page adds an
// output latch, a TX byte FIFO and a 16-bit cycle counter.
//
// Build option:
//   MEM_IO_EN  - when defined, 0xFF00-0xFFFF is the I/O page (OUT, TX, STATUS,
//                CNT_LO, CNT_HI). When undefined, the whole 64 KiB maps to RAM,
//                and out_port/tx_valid/tx_data are tied to zero.
//
// Parameters:
//   AW          RAM size is 2^AW bytes
//   FIFO_DEPTH  TX FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   addr, wdata, we     CPU address, write data and write strobe
//   rdata               read data, registered (one cycle after addr)
//   cpu_rst             reset to the CPU, high except in RUN
//   ld_start            pulse that starts a program load
//   ld_valid, ld_data,
//   ld_last, ld_ready   loader byte stream (accepted on ld_valid & ld_ready)
//   out_port            output latch (I/O 0xFF00)
//   tx_valid, tx_data,
//   tx_ready            TX FIFO head and pop strobe
module sys_bus_mem #(
  parameter int AW         = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic        we,
  output logic        cpu_rst,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic [7:0]  out_port,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  typedef enum logic [1:0] {HOLD, LOAD, RUN} state_t;
  typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_IO} rd_sel_t;

  state_t         state;
  rd_sel_t        rd_sel;
  logic [AW-1:0]  ptr;
  logic [7:0]     mem [0:(1<<AW)-1];
  logic [7:0]     ram_rd;

  logic run;
  logic enter_load;
  logic ld_accept;
  logic is_io;
  logic ram_we;

  assign run        = (state == RUN);
  assign enter_load = ld_start && (state != LOAD);
  // ld_ready is registered high exactly while in LOAD
  assign ld_accept  = ld_ready && ld_valid;
  assign ram_we     = run && we && !is_io;

`ifdef MEM_IO_EN
  assign is_io = (addr[15:8] == 8'hFF);
`else
  assign is_io = 1'b0;
`endif

  // Control FSM; cpu_rst and ld_ready are registered alongside the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HOLD;
      cpu_rst  <= 1'b1;
      ld_ready <= 1'b0;
      ptr      <= '0;
    end else begin
      case (state)
        HOLD, RUN: begin
          if (enter_load) begin
            state    <= LOAD;
            cpu_rst  <= 1'b1;
            ld_ready <= 1'b1;
            ptr      <= '0;
          end
        end
        LOAD: begin
          if (ld_accept) begin
            ptr <= ptr + 1'b1;
            if (ld_last) begin
              state    <= RUN;
              cpu_rst  <= 1'b0;
              ld_ready <= 1'b0;
            end
          end
        end
        default: begin
          state    <= HOLD;
          cpu_rst  <= 1'b1;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

  // RAM: loader and CPU never write in the same state; read returns old data
  always_ff @(posedge clk) begin
    if (ld_accept)
      mem[ptr] <= ld_data;
    else if (ram_we)
      mem[addr[AW-1:0]] <= wdata;
    ram_rd <= mem[addr[AW-1:0]];
  end

  // Remembers which source drives rdata for the cycle after the address
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_sel <= SEL_ZERO;
    else if (!run)
      rd_sel <= SEL_ZERO;
    else if (is_io)
      rd_sel <= SEL_IO;
    else
      rd_sel <= SEL_RAM;
  end

`ifdef MEM_IO_EN
  localparam int FW = $clog2(FIFO_DEPTH);

  logic [7:0]  out_reg;
  logic [7:0]  io_rd_q;
  logic [7:0]  io_rdata;
  logic [15:0] counter;
  logic [7:0]  shadow;
  logic        overflow;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [FW:0] wr_ptr;
  logic [FW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push_req;
  logic        push_ok;

  // Pointers carry one extra wrap bit to tell full from empty
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FW] != rd_ptr[FW]) &&
                      (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
  assign pop        = tx_ready && !fifo_empty;
  assign push_req   = run && we && (addr == 16'hFF01);
  // A push into a full FIFO still fits if the head leaves on the same edge
  assign push_ok    = push_req && (!fifo_full || pop);

  assign out_port = out_reg;
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[FW-1:0]];

  always_comb begin
    io_rdata = 8'h00;
    case (addr[7:0])
      8'h00:   io_rdata = out_reg;
      8'h02:   io_rdata = {5'b0, overflow, fifo_empty, fifo_full};
      8'h03:   io_rdata = counter[7:0];
      8'h04:   io_rdata = shadow;
      default: io_rdata = 8'h00;
    endcase
  end

  // I/O registers; entering LOAD flushes the FIFO and clears counter/overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg  <= 8'h00;
      io_rd_q  <= 8'h00;
      counter  <= 16'h0000;
      shadow   <= 8'h00;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (enter_load) begin
      counter  <= 16'h0000;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      io_rd_q <= io_rdata;
      if (run)
        counter <= counter + 1'b1;
      // Snapshot the high byte so CNT_LO then CNT_HI is one coherent value
      if (run && addr == 16'hFF03)
        shadow <= counter[15:8];
      if (run && we && addr == 16'hFF00)
        out_reg <= wdata;
      if (run && we && addr == 16'hFF02)
        overflow <= 1'b0;
      else if (push_req && fifo_full && !pop)
        overflow <= 1'b1;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok && !enter_load)
      fifo_mem[wr_ptr[FW-1:0]] <= wdata;
  end
`else
  logic unused_bits;

  assign out_port    = 8'h00;
  assign tx_valid    = 1'b0;
  assign tx_data     = 8'h00;
  assign unused_bits = ^{tx_ready, addr[15:AW], FIFO_DEPTH[0]};
`endif

  always_comb begin
    rdata = 8'h00;
    case (rd_sel)
      SEL_RAM: rdata = ram_rd;
`ifdef MEM_IO_EN
      SEL_IO:  rdata = io_rd_q;
`endif
      default: rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_sys_bus_mem.sv
// Testbench for sys_bus_mem: loads a program image, exercises RAM reads and
// writes, the I/O page when MEM_IO_EN is defined (RAM aliasing otherwise),
// and reset in the middle of a load. Read expectations go through a
// scoreboard queue and are compared when rdata becomes valid.
module tb_sys_bus_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        we;
  logic        cpu_rst;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [7:0]  out_port;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int c_run = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  sys_bus_mem #(.AW(12), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .we       (we),
    .cpu_rst  (cpu_rst),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .out_port (out_port),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle; when chk is set, the expected rdata is queued and checked
  // once the registered read data appears after the edge
  task automatic applyStimulus(input logic [15:0] a, input logic w,
                               input logic [7:0] d, input bit chk,
                               input logic [7:0] exp, input string tag);
    exp_t e;
    addr  = a;
    we    = w;
    wdata = d;
    if (chk) begin
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    if (chk) begin
      e = sb.pop_front();
      checkOutput(e.tag, {8'h00, rdata}, {8'h00, e.exp});
    end
  endtask

  task automatic loadBeat(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulseStart();
    ld_start = 1'b1;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] cv;
    rst      = 1'b1;
    addr     = 16'h0000;
    wdata    = 8'h00;
    we       = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
    ld_last  = 1'b0;
    tx_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rdata",    {8'h00, rdata},    16'h0000);
    checkOutput("reset_cpu_rst",  {15'h0, cpu_rst},  16'h0001);
    checkOutput("reset_ld_ready", {15'h0, ld_ready}, 16'h0000);
    checkOutput("reset_out_port", {8'h00, out_port}, 16'h0000);
    checkOutput("reset_tx_valid", {15'h0, tx_valid}, 16'h0000);
    checkOutput("reset_tx_data",  {8'h00, tx_data},  16'h0000);
    rst = 1'b0;

    @(posedge clk);
    #1;
    checkOutput("hold_ld_ready", {15'h0, ld_ready}, 16'h0000);

    // Program load
    pulseStart();
    checkOutput("load_ld_ready", {15'h0, ld_ready}, 16'h0001);
    checkOutput("load_cpu_rst",  {15'h0, cpu_rst},  16'h0001);
    loadBeat(8'h11, 1'b0);
    loadBeat(8'h22, 1'b0);
    applyStimulus(16'h0001, 1'b1, 8'hEE, 1'b1, 8'h00, "load_rdata_zero");
    checkOutput("cpu_rst_mid_load", {15'h0, cpu_rst}, 16'h0001);
    loadBeat(8'h33, 1'b1);
    c_run = cyc;
    checkOutput("run_cpu_rst",  {15'h0, cpu_rst},  16'h0000);
    checkOutput("run_ld_ready", {15'h0, ld_ready}, 16'h0000);

    // RAM contents from the image and CPU read/write
    applyStimulus(16'h0000, 1'b0, 8'h00, 1'b1, 8'h11, "ram0");
    applyStimulus(16'h0001, 1'b0, 8'h00, 1'b1, 8'h22, "ram1");
    applyStimulus(16'h0002, 1'b0, 8'h00, 1'b1, 8'h33, "ram2");
    applyStimulus(16'h0010, 1'b1, 8'h5A, 1'b0, 8'h00, "");
    applyStimulus(16'h0010, 1'b0, 8'h00, 1'b1, 8'h5A, "ram_rw");
    applyStimulus(16'h1010, 1'b0, 8'h00, 1'b1, 8'h5A, "ram_alias");
    applyStimulus(16'h0010, 1'b1, 8'h77, 1'b1, 8'h5A, "rd_during_wr_old");
    applyStimulus(16'h0010, 1'b0, 8'h00, 1'b1, 8'h77, "rd_after_wr_new");

`ifdef MEM_IO_EN
    applyStimulus(16'hFF00, 1'b1, 8'hC3, 1'b0, 8'h00, "");
    checkOutput("out_port", {8'h00, out_port}, 16'h00C3);
    applyStimulus(16'hFF00, 1'b0, 8'h00, 1'b1, 8'hC3, "out_readback");

    // Fill the FIFO past its depth with the sink stalled
    for (int i = 0; i < 9; i++)
      applyStimulus(16'hFF01, 1'b1, 8'hA0 + 8'(i), (i == 0), 8'h00, "tx_read_zero");
    checkOutput("tx_valid_full", {15'h0, tx_valid}, 16'h0001);
    checkOutput("tx_head",       {8'h00, tx_data},  16'h00A0);
    applyStimulus(16'hFF02, 1'b0, 8'h00, 1'b1, 8'h05, "status_overflow");
    applyStimulus(16'hFF02, 1'b1, 8'h00, 1'b0, 8'h00, "");
    applyStimulus(16'hFF02, 1'b0, 8'h00, 1'b1, 8'h01, "status_cleared");

    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("tx_order", {8'h00, tx_data}, {8'h00, 8'hA0 + 8'(i)});
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    checkOutput("tx_valid_drained", {15'h0, tx_valid}, 16'h0000);
    checkOutput("tx_data_drained",  {8'h00, tx_data},  16'h0000);
    applyStimulus(16'hFF02, 1'b0, 8'h00, 1'b1, 8'h02, "status_empty");

    // Cycle counter snapshot
    addr = 16'h0000;
    repeat (300) @(posedge clk);
    #1;
    cv = 16'(cyc - c_run);
    applyStimulus(16'hFF03, 1'b0, 8'h00, 1'b1, cv[7:0],  "cnt_lo");
    applyStimulus(16'hFF04, 1'b0, 8'h00, 1'b1, cv[15:8], "cnt_hi");

    // Reload flushes FIFO and counter
    applyStimulus(16'hFF01, 1'b1, 8'h99, 1'b0, 8'h00, "");
    checkOutput("tx_valid_before_reload", {15'h0, tx_valid}, 16'h0001);
    addr = 16'h0000;
    pulseStart();
    checkOutput("reload_cpu_rst",  {15'h0, cpu_rst},  16'h0001);
    checkOutput("reload_tx_valid", {15'h0, tx_valid}, 16'h0000);
    checkOutput("reload_tx_data",  {8'h00, tx_data},  16'h0000);
    applyStimulus(16'hFF00, 1'b0, 8'h00, 1'b1, 8'h00, "load_io_read_zero");
    loadBeat(8'h44, 1'b1);
    applyStimulus(16'hFF03, 1'b0, 8'h00, 1'b1, 8'h00, "cnt_cleared");
    applyStimulus(16'h0000, 1'b0, 8'h00, 1'b1, 8'h44, "ptr_restart");
`else
    applyStimulus(16'hFF10, 1'b1, 8'h6B, 1'b0, 8'h00, "");
    applyStimulus(16'h0F10, 1'b0, 8'h00, 1'b1, 8'h6B, "alias_top_low");
    applyStimulus(16'hFF10, 1'b0, 8'h00, 1'b1, 8'h6B, "alias_top_high");
    applyStimulus(16'hFF00, 1'b1, 8'hC3, 1'b0, 8'h00, "");
    checkOutput("out_port_tied",  {8'h00, out_port}, 16'h0000);
    checkOutput("tx_valid_tied",  {15'h0, tx_valid}, 16'h0000);
    checkOutput("tx_data_tied",   {8'h00, tx_data},  16'h0000);
    applyStimulus(16'h0F00, 1'b0, 8'h00, 1'b1, 8'hC3, "ff00_is_ram");
`endif

    // Reset in the middle of a load
    addr = 16'h0000;
    pulseStart();
    loadBeat(8'hD1, 1'b0);
    loadBeat(8'hD2, 1'b0);
    checkOutput("abort_ld_ready_before", {15'h0, ld_ready}, 16'h0001);
    rst = 1'b1;
    #2;
    checkOutput("abort_ld_ready", {15'h0, ld_ready}, 16'h0000);
    checkOutput("abort_cpu_rst",  {15'h0, cpu_rst},  16'h0001);
    @(posedge clk);
    #1;
    rst = 1'b0;
    loadBeat(8'hFF, 1'b1);
    checkOutput("hold_ignores_beat", {15'h0, cpu_rst}, 16'h0001);
    applyStimulus(16'h0010, 1'b1, 8'h99, 1'b1, 8'h00, "hold_rdata_zero");
    pulseStart();
    loadBeat(8'h55, 1'b1);
    applyStimulus(16'h0010, 1'b0, 8'h00, 1'b1, 8'h77, "hold_write_ignored");
    applyStimulus(16'h0000, 1'b0, 8'h00, 1'b1, 8'h55, "reload_ram0");
    applyStimulus(16'h0001, 1'b0, 8'h00, 1'b1, 8'hD2, "abort_ram1_kept");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sys_bus_mem.md
# sys_bus_mem

Byte-wide memory and I/O responder sitting on the CPU's 16-bit address / 8-bit data bus, i.e. the far end of the CPU's `addr`/`do`/`we` initiator port. It holds program and data RAM, drives the CPU's reset while a program image is streamed in over a valid/ready loader port, and (optionally) exposes a small memory-mapped I/O page: an output latch, a TX byte FIFO and a cycle counter.

## Interface
- AW, 12, RAM size is 2^AW bytes
- FIFO_DEPTH, 8, TX FIFO entries (power of two, >=2)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- addr  in  16  CPU byte address
- wdata  in  8  CPU write data (CPU `do`)
- rdata  out  8  read data to CPU (CPU `di`)
- we  in  1  CPU write strobe
- cpu_rst  out  1  reset to CPU, high while not in RUN
- ld_start  in  1  begin program load (pulse)
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte
- ld_last  in  1  final byte of image, qualified by ld_valid
- ld_ready  out  1  loader byte accepted when ld_valid&ld_ready
- out_port  out  8  output latch
- tx_valid  out  1  TX FIFO non-empty
- tx_data  out  8  TX FIFO head byte, 0x00 when empty
- tx_ready  in  1  TX sink pop

## Operation
- Control FSM: HOLD, LOAD, RUN. Reset -> HOLD.
  - HOLD: cpu_rst=1, ld_ready=0. ld_start -> LOAD.
  - LOAD: cpu_rst=1, ld_ready=1. Each accepted beat writes ld_data to RAM[ptr], ptr++ (wraps mod 2^AW). Accepted beat with ld_last -> RUN. ld_start ignored.
  - RUN: cpu_rst=0, ld_ready=0. ld_start -> LOAD.
  - Entering LOAD: ptr=0, TX FIFO flushed, cycle counter cleared, overflow cleared.
- CPU bus serviced only in RUN; in HOLD/LOAD `we` ignored, rdata=0x00.
- Address map (RUN): addr<0xFF00 -> RAM[addr[AW-1:0]] (aliases). 0xFF00-0xFFFF -> I/O page (see Configuration).
- I/O page: 0xFF00 OUT (rw, out_port). 0xFF01 TX (write pushes wdata; read 0x00). 0xFF02 STATUS read {5'b0, overflow, empty, full}; any write clears overflow. 0xFF03 CNT_LO read returns counter[7:0] and snapshots counter[15:8] into shadow. 0xFF04 CNT_HI read returns shadow. Others: read 0x00, writes ignored.
- Push when full with no simultaneous pop: byte dropped, overflow set (sticky). Push and pop same cycle when full: both succeed, no overflow. Pop on empty: no effect.
- Cycle counter: 16-bit, increments every RUN cycle, wraps 0xFFFF->0x0000.
- Loader never writes the I/O page.

## Timing
- Reset values: rdata=0x00, cpu_rst=1, ld_ready=0, out_port=0x00, tx_valid=0, tx_data=0x00, counter=0, shadow=0, overflow=0, FSM=HOLD. RAM contents not reset.
- Read: addr sampled at edge N, rdata valid after edge N (1-cycle registered latency), held until next edge.
- Write: performed at the edge where we=1 in RUN. Read and write same address same edge: rdata returns old contents.
- cpu_rst and ld_ready are registered from FSM state: ld_start at edge N -> ld_ready=1, cpu_rst=1 after edge N; last beat at edge M -> cpu_rst=0, ld_ready=0 after edge M.
- tx_valid rises the cycle after the push edge.
- rst asserted mid-load or mid-run: immediate return to reset values; load must be restarted.

## Configuration
- MEM_IO_EN defined: I/O page at 0xFF00-0xFFFF as above.
- MEM_IO_EN undefined: no I/O page; all 64 KiB map to RAM[addr[AW-1:0]]; out_port, tx_valid, tx_data tied 0x00/0; FIFO and counter not built.

## Test plan
- Reset, ld_start, stream 0x11,0x22,0x33 (last on 0x33) -> RAM[0..2]=11,22,33; cpu_rst drops one cycle after last beat.
- RUN: write 0x5A @0x0010, read 0x0010 next cycle -> rdata=0x5A one cycle after addr; read 0x1010 (AW=12) -> 0x5A.
- Write 0xC3 @0xFF00 -> out_port=0xC3; read 0xFF00 -> 0xC3.
- tx_ready=0, push 9 bytes to 0xFF01 (depth 8) -> STATUS=0x05; write 0xFF02 -> STATUS=0x01; tx_ready=1 drains 8 bytes in order.
- 300 RUN cycles then read 0xFF03, 0xFF04 -> consistent 16-bit snapshot; ld_start -> counter 0, FIFO empty, cpu_rst=1.
- Assert rst mid-load after 2 beats -> FSM HOLD, ld_ready=0, cpu_rst=1; bus writes ignored.
